vector_alu_pipe: RTL and testbench
==================================

VECTOR_ALU_PIPE -- requirements
Module: vector_alu_pipe

Interface
REQ-001 SHALL have parameter N, default 18, lane width in bits (N >= 4).
REQ-002 SHALL have parameter V, default 3, lane count (V >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port A  input  [V-1:0][N-1:0]  operand vector A.
REQ-008 SHALL have port B  input  [V-1:0][N-1:0]  operand vector B.
REQ-009 SHALL have port C  input  3  opcode.
REQ-010 SHALL have port out_valid  output  1  result presented.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port R  output  [V-1:0][N-1:0]  result vector.
REQ-013 SHALL have port LF  output  [V-1:0][3:0]  per-lane flags {N,Z,C,V}.
REQ-014 SHALL have port F  output  4  aggregate flags: F[3] negative, F[2] zero, F[1] carry, F[0] overflow.

Function
REQ-015 SHALL implement opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL (low N bits), 101 CONV (dot product), 110 XOR, 111 MOV (R=B).
REQ-016 SHALL run CONV as sum over i of A[i]*B[i], truncated to N bits, in R[0]; lanes 1..V-1 = 0.
REQ-017 SHALL be a two-stage pipeline: operand register, then result register; out_valid rises 2 cycles after in_valid&in_ready with no stall.
REQ-018 SHALL transfer input only on in_valid&in_ready; output only on out_valid&out_ready.
REQ-019 SHALL drive advance = !out_valid | out_ready; in_ready = !s1_valid | advance; in_ready = 0 while reset is high.
REQ-020 SHALL hold R, LF, F, out_valid stable while out_valid&!out_ready; no beat lost or duplicated.
REQ-021 SHALL sustain one result per cycle while in_valid and out_ready stay high.
REQ-022 SHALL accept a new input in the same cycle a result is consumed with the pipeline full.
REQ-023 SHALL compute lane N = R[i][N-1]; Z = (R[i]==0).
REQ-024 SHALL compute lane C: ADD carry out of bit N-1; SUB 1 when A>=B unsigned; MUL/CONV 1 when any truncated product/sum bit is nonzero; else 0.
REQ-025 SHALL compute lane V: signed overflow for ADD/SUB; 0 for all other opcodes.
REQ-026 SHALL set F[3], F[1], F[0] from lane V-1; F[2] = 1 only when all V lanes are zero.
REQ-027 SHALL wrap ADD/SUB results modulo 2^N when saturation is compiled out.

Reset
REQ-028 SHALL, on reset, clear out_valid, all internal valid bits, R, LF and F to 0 on the next edge.
REQ-029 SHALL discard in-flight operations on reset; no result for them ever appears.
REQ-030 SHALL accept inputs starting the first cycle after reset deasserts.

Configuration
REQ-031 SHALL provide macro VECTOR_ALU_SAT_EN.
REQ-032 SHALL, with VECTOR_ALU_SAT_EN defined, clamp signed-overflowing ADD/SUB lanes to 2^(N-1)-1 (positive) or -2^(N-1) (negative); lane V flag still 1; N/Z from the clamped value.
REQ-033 SHALL, without VECTOR_ALU_SAT_EN, wrap per REQ-027; other opcodes are identical in both builds.

Verification
REQ-034 SHALL test ADD, N=18, lane2 A=0x1FFFF, B=0x00001, out_ready=1 -> R[2]=0x20000, F=4'b1001 two cycles later (SAT_EN: R[2]=0x1FFFF, F=4'b0001).
REQ-035 SHALL test SUB, all lanes A=B=0x00123 -> R=0 all lanes, F[2]=1, F[1]=1, F[0]=0.
REQ-036 SHALL test CONV, V=3, A={2,3,4}, B={5,6,7} -> R[0]=56, R[1]=R[2]=0, F[1]=0.
REQ-037 SHALL test back-to-back: 4 beats, out_ready low for cycles 3-5 -> in_ready low once full; R stable while stalled; 4 results in order, none lost.
REQ-038 SHALL test reset mid-flight: 2 beats issued, reset high one cycle -> out_valid=0, R=0, F=0 next cycle; no stale result afterward.

Source files
------------

// File: rtl/vector_alu_pipe_if.sv
// Operand/result bus for vector_alu_pipe.
// The master side issues operand sets and consumes results; the slave side is
// the ALU pipeline.
interface vector_alu_pipe_if #(
   parameter int N = 18,
   parameter int V = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [V-1:0][N-1:0]   A;
   logic [V-1:0][N-1:0]   B;
   logic [2:0]            C;
   logic                  out_valid;
   logic                  out_ready;
   logic [V-1:0][N-1:0]   R;
   logic [V-1:0][3:0]     LF;
   logic [3:0]            F;

   modport master (
      output in_valid, A, B, C, out_ready,
      input  in_ready, out_valid, R, LF, F
   );

   modport slave (
      input  in_valid, A, B, C, out_ready,
      output in_ready, out_valid, R, LF, F
   );
endinterface

// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe: V-lane, N-bit vector ALU with a two-stage valid/ready
// pipeline (operand register -> result register).
// Opcodes: ADD SUB AND OR MUL CONV(dot product into lane 0) XOR MOV.
// Optional feature macro VECTOR_ALU_SAT_EN: signed-overflowing ADD/SUB lanes
// clamp to the signed max/min instead of wrapping.

// Single lane datapath: everything except CONV, plus the full product that
// the top level sums for the dot product.
module vector_alu_lane #(
   parameter int N = 18
) (
   input  logic [2:0]     op_i,
   input  logic [N-1:0]   a_i,
   input  logic [N-1:0]   b_i,
   output logic [N-1:0]   r_o,
   output logic           c_o,
   output logic           v_o,
   output logic [2*N-1:0] prod_o
);
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_MOV = 3'b111;

`ifdef VECTOR_ALU_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic [N:0]   sum_w;
   logic [N-1:0] diff_w;
   logic         add_ovf;
   logic         sub_ovf;
   logic [N-1:0] sat_val;

   assign sum_w   = {1'b0, a_i} + {1'b0, b_i};
   assign diff_w  = a_i - b_i;
   assign prod_o  = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};
   // Signed overflow: like-signed operands (ADD) or unlike-signed (SUB)
   // producing a result whose sign differs from A.
   assign add_ovf = (a_i[N-1] == b_i[N-1]) && (sum_w[N-1] != a_i[N-1]);
   assign sub_ovf = (a_i[N-1] != b_i[N-1]) && (diff_w[N-1] != a_i[N-1]);
   // On overflow the true result always has A's sign, so A picks the rail.
   assign sat_val = a_i[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

   // Per-opcode result, carry and overflow for this lane.
   always_comb begin
      r_o = '0;
      c_o = 1'b0;
      v_o = 1'b0;
      case (op_i)
         OP_ADD: begin
            r_o = sum_w[N-1:0];
            c_o = sum_w[N];
            v_o = add_ovf;
            if (SAT_EN && add_ovf) r_o = sat_val;
         end
         OP_SUB: begin
            r_o = diff_w;
            c_o = (a_i >= b_i);
            v_o = sub_ovf;
            if (SAT_EN && sub_ovf) r_o = sat_val;
         end
         OP_AND: r_o = a_i & b_i;
         OP_OR:  r_o = a_i | b_i;
         OP_MUL: begin
            r_o = prod_o[N-1:0];
            c_o = |prod_o[2*N-1:N];
         end
         OP_XOR: r_o = a_i ^ b_i;
         OP_MOV: r_o = b_i;
         default: ;  // CONV is assembled at the vector level
      endcase
   end
endmodule

module vector_alu_pipe #(
   parameter int N = 18,
   parameter int V = 3
) (
   input logic               clk,
   input logic               reset,
   vector_alu_pipe_if.slave  bus
);
   localparam logic [2:0] OP_CONV = 3'b101;
   // Dot-product accumulator wide enough for V full products.
   localparam int SW = 2*N + $clog2(V) + 1;

   // Stage 1: operand register
   logic                 s1_valid_q, s1_valid_d;
   logic [V-1:0][N-1:0]  a_q, a_d;
   logic [V-1:0][N-1:0]  b_q, b_d;
   logic [2:0]           op_q, op_d;

   // Stage 2: result register
   logic                 out_valid_q, out_valid_d;
   logic [V-1:0][N-1:0]  r_q, r_d;
   logic [V-1:0][3:0]    lf_q, lf_d;
   logic [3:0]           f_q, f_d;

   logic                 advance;
   logic                 in_ready;
   logic                 accept;

   logic [V-1:0][N-1:0]   lane_r;
   logic [V-1:0]          lane_c;
   logic [V-1:0]          lane_v;
   logic [V-1:0][2*N-1:0] lane_prod;
   logic [SW-1:0]         conv_sum;

   logic [V-1:0][N-1:0]  res_r;
   logic [V-1:0][3:0]    res_lf;
   logic [3:0]           res_f;

   // Result stage frees up when empty or being drained; operand stage can
   // take a new set when empty or when it is moving forward this cycle.
   assign advance  = !out_valid_q || bus.out_ready;
   assign in_ready = !reset && (!s1_valid_q || advance);
   assign accept   = bus.in_valid && in_ready;

   for (genvar gi = 0; gi < V; gi++) begin : g_lane
      vector_alu_lane #(.N(N)) u_lane (
         .op_i   (op_q),
         .a_i    (a_q[gi]),
         .b_i    (b_q[gi]),
         .r_o    (lane_r[gi]),
         .c_o    (lane_c[gi]),
         .v_o    (lane_v[gi]),
         .prod_o (lane_prod[gi])
      );
   end

   // Dot product: sum of all full-width lane products.
   always_comb begin
      conv_sum = '0;
      for (int i = 0; i < V; i++)
         conv_sum = conv_sum + {{(SW-2*N){1'b0}}, lane_prod[i]};
   end

   // Assemble the result vector and lane/aggregate flags {N,Z,C,V}.
   always_comb begin
      res_r  = '0;
      res_lf = '0;
      for (int i = 0; i < V; i++) begin
         if (op_q == OP_CONV) begin
            if (i == 0) begin
               res_r[i]     = conv_sum[N-1:0];
               res_lf[i][1] = |conv_sum[SW-1:N];
            end
         end else begin
            res_r[i]     = lane_r[i];
            res_lf[i][1] = lane_c[i];
            res_lf[i][0] = lane_v[i];
         end
         res_lf[i][3] = res_r[i][N-1];
         res_lf[i][2] = (res_r[i] == '0);
      end
      res_f = {res_lf[V-1][3], (res_r == '0), res_lf[V-1][1], res_lf[V-1][0]};
   end

   // Next-state for both pipeline stages.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      out_valid_d = out_valid_q;
      r_d         = r_q;
      lf_d        = lf_q;
      f_d         = f_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         a_d        = bus.A;
         b_d        = bus.B;
         op_d       = bus.C;
      end else if (advance) begin
         s1_valid_d = 1'b0;
      end
      if (advance) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            r_d  = res_r;
            lf_d = res_lf;
            f_d  = res_f;
         end
      end
   end

   // Pipeline registers; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         out_valid_q <= 1'b0;
         r_q         <= '0;
         lf_q        <= '0;
         f_q         <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         out_valid_q <= out_valid_d;
         r_q         <= r_d;
         lf_q        <= lf_d;
         f_q         <= f_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.R         = r_q;
   assign bus.LF        = lf_q;
   assign bus.F         = f_q;
endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench for vector_alu_pipe: accepted operand sets push an
// arithmetic-model prediction; a negedge monitor pops on each consumed result.
module tb_vector_alu_pipe;
   localparam int N = 18;
   localparam int V = 3;
   localparam longint unsigned MOD  = 64'd1 << N;
   localparam longint unsigned HALF = 64'd1 << (N-1);
   localparam longint SMAX = longint'(HALF) - 1;
   localparam longint SMIN = -longint'(HALF);

`ifdef VECTOR_ALU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef logic [V-1:0][N-1:0] vec_t;
   typedef struct packed {
      vec_t              r;
      logic [V-1:0][3:0] lf;
      logic [3:0]        f;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vector_alu_pipe_if #(.N(N), .V(V)) bus ();
   vector_alu_pipe #(.N(N), .V(V)) dut (.clk(clk), .reset(reset), .bus(bus));

   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];
   bit   saw_full = 0;
   bit   stim_done = 0;
   bit   prev_stall = 0;
   exp_t held;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model from the opcode rules, using plain integer arithmetic.
   function automatic exp_t model(input vec_t a, input vec_t b, input logic [2:0] op);
      exp_t e;
      longint unsigned ua, ub, full, csum;
      longint sa, sb, ss;
      bit cf[V];
      bit vf[V];
      e = '0;
      csum = 0;
      for (int i = 0; i < V; i++) begin
         ua = longint'(a[i]);
         ub = longint'(b[i]);
         sa = (ua >= HALF) ? longint'(ua) - longint'(MOD) : longint'(ua);
         sb = (ub >= HALF) ? longint'(ub) - longint'(MOD) : longint'(ub);
         cf[i] = 0;
         vf[i] = 0;
         case (op)
            3'd0: begin
               full = ua + ub;
               e.r[i] = N'(full % MOD);
               cf[i] = (full >= MOD);
               ss = sa + sb;
               vf[i] = (ss > SMAX) || (ss < SMIN);
               if (SAT && vf[i]) e.r[i] = (ss > SMAX) ? N'(SMAX) : N'(SMIN);
            end
            3'd1: begin
               e.r[i] = N'((ua + MOD - ub) % MOD);
               cf[i] = (ua >= ub);
               ss = sa - sb;
               vf[i] = (ss > SMAX) || (ss < SMIN);
               if (SAT && vf[i]) e.r[i] = (ss > SMAX) ? N'(SMAX) : N'(SMIN);
            end
            3'd2: e.r[i] = a[i] & b[i];
            3'd3: e.r[i] = a[i] | b[i];
            3'd4: begin
               full = ua * ub;
               e.r[i] = N'(full % MOD);
               cf[i] = (full >= MOD);
            end
            3'd5: csum = csum + ua * ub;
            3'd6: e.r[i] = a[i] ^ b[i];
            default: e.r[i] = b[i];
         endcase
      end
      if (op == 3'd5) begin
         e.r[0] = N'(csum % MOD);
         cf[0] = (csum >= MOD);
      end
      for (int i = 0; i < V; i++)
         e.lf[i] = {e.r[i] >= N'(HALF), e.r[i] == 0, cf[i], vf[i]};
      e.f = {e.lf[V-1][3], e.r == '0, e.lf[V-1][1], e.lf[V-1][0]};
      return e;
   endfunction

   // Monitor: handshake bookkeeping, in_ready rule, hold-while-stalled, scoreboard.
   always @(negedge clk) begin
      exp_t got, e;
      if (reset) begin
         exp_q.delete();
         prev_stall = 0;
         chk("in_ready_rst", {127'd0, bus.in_ready}, 128'd0);
      end else begin
         chk("in_ready", {127'd0, bus.in_ready},
             {127'd0, (exp_q.size() < 2) || bus.out_ready});
         if (exp_q.size() >= 2 && !bus.out_ready) saw_full = 1;
         got = '{r: bus.R, lf: bus.LF, f: bus.F};
         if (prev_stall) begin
            chk("hold_valid", {127'd0, bus.out_valid}, 128'd1);
            chk("hold_data", 128'(got), 128'(held));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_out: got R=%0h expected no result", bus.R);
            end else begin
               e = exp_q.pop_front();
               chk("R", 128'(got.r), 128'(e.r));
               chk("LF", 128'(got.lf), 128'(e.lf));
               chk("F", 128'(got.f), 128'(e.f));
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         held = got;
         if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.A, bus.B, bus.C));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one operand set and hold it until accepted (bounded).
   task automatic send(input vec_t a, input vec_t b, input logic [2:0] op);
      bus.A = a;
      bus.B = b;
      bus.C = op;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            step(1);
            bus.in_valid = 1'b0;
            return;
         end
         step(1);
      end
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance within 60 cycles");
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [N-1:0] rnd_lane();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return N'(MOD - 1);
         2: return N'(HALF - 1);
         3: return N'(HALF);
         default: return N'($urandom);
      endcase
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      for (int i = 0; i < V; i++) v[i] = rnd_lane();
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish before 500us");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t a, b;
      int stale;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.C = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
      chk("rst_R", 128'(bus.R), 128'd0);
      chk("rst_LF", 128'(bus.LF), 128'd0);
      chk("rst_F", 128'(bus.F), 128'd0);
      step(1);
      reset = 1'b0;
      bus.out_ready = 1'b1;

      // ADD overflow on lane 2, with two-cycle latency check
      a = '0; b = '0;
      a[2] = 18'h1FFFF; b[2] = 18'h00001;
      send(a, b, 3'd0);
      @(negedge clk);
      chk("add_lat_early", {127'd0, bus.out_valid}, 128'd0);
      @(negedge clk);
      chk("add_lat", {127'd0, bus.out_valid}, 128'd1);
      chk("add_R2", 128'(bus.R[2]), SAT ? 128'h1FFFF : 128'h20000);
      chk("add_F", 128'(bus.F), SAT ? 128'b0001 : 128'b1001);
      step(1);

      // SUB equal operands
      for (int i = 0; i < V; i++) begin a[i] = 18'h00123; b[i] = 18'h00123; end
      send(a, b, 3'd1);
      step(1);
      @(negedge clk);
      chk("sub_R", 128'(bus.R), 128'd0);
      chk("sub_F", 128'(bus.F[2:0]), 128'b110);
      step(1);

      // CONV dot product
      a[0] = 2; a[1] = 3; a[2] = 4;
      b[0] = 5; b[1] = 6; b[2] = 7;
      send(a, b, 3'd5);
      step(1);
      @(negedge clk);
      chk("conv_R0", 128'(bus.R[0]), 128'd56);
      chk("conv_R12", {bus.R[2], bus.R[1]}, 128'd0);
      chk("conv_F1", {127'd0, bus.F[1]}, 128'd0);
      step(1);

      // Back-to-back with a three-cycle consumer stall
      saw_full = 0;
      fork
         for (int k = 0; k < 4; k++) send(rnd_vec(), rnd_vec(), 3'($urandom_range(0, 7)));
         begin
            step(2);
            bus.out_ready = 1'b0;
            step(3);
            bus.out_ready = 1'b1;
         end
      join
      step(6);
      chk("b2b_full_seen", {127'd0, saw_full}, 128'd1);
      chk("b2b_drained", 128'(exp_q.size()), 128'd0);

      // Reset with two beats in flight
      bus.out_ready = 1'b0;
      send(rnd_vec(), rnd_vec(), 3'd0);
      send(rnd_vec(), rnd_vec(), 3'd4);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      @(negedge clk);
      chk("rstmid_out_valid", {127'd0, bus.out_valid}, 128'd0);
      chk("rstmid_R", 128'(bus.R), 128'd0);
      chk("rstmid_F", 128'(bus.F), 128'd0);
      step(1);
      bus.out_ready = 1'b1;
      stale = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      chk("rstmid_no_stale", 128'(stale), 128'd0);
      step(1);

      // Randomized traffic with random consumer back-pressure
      stim_done = 0;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               send(rnd_vec(), rnd_vec(), 3'($urandom_range(0, 7)));
               if ($urandom_range(0, 4) == 0) step(1);
            end
            stim_done = 1;
         end
         while (!stim_done) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step(1);
         end
      join
      bus.out_ready = 1'b1;
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) step(1);
      chk("final_drain", 128'(exp_q.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
